inst_fetch_port: RTL and testbench
==================================

# inst_fetch_port

Responder side of the instruction-fetch interface: accepts `pc`/`ce` from the PC register and returns the instruction to the IF/ID stage. Translates kseg0/kseg1 addresses, runs a single-outstanding req/ack transaction to instruction memory, holds the result in a one-entry buffer across pipeline stalls, and requests a pipeline stall from CTRL while a fetch is pending. Sits between the PC register, instruction memory, IF/ID and CTRL.

## Interface
- No parameters; all buses are 32 bits (`RegBus`/`InstAddrBus`/`InstBus`).
- `clk` in 1: sole clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `ce_i` in 1: fetch enable from PC register.
- `pc_i` in 32: fetch address from PC register.
- `stall_i` in 1: IF/ID not accepting this cycle (CTRL stall bit for IF).
- `flush_i` in 1: pipeline flush from CTRL.
- `inst_o` out 32: instruction to IF/ID; 0 (nop) whenever `inst_valid_o`=0.
- `inst_valid_o` out 1: `inst_o` is the instruction at `pc_i`.
- `exc_adel_o` out 1: fetch address misaligned.
- `stallreq_o` out 1: stall request to CTRL.
- `mem_req_o` out 1, `mem_addr_o` out 32: memory request and physical address.
- `mem_ack_i` in 1, `mem_rdata_i` in 32: memory acknowledge; data valid in the ack cycle.

## Operation
- Translation: if `pc[31:30]`=2'b10, phys = {3'b000, pc[28:0]}; otherwise phys = pc (0xbfc00000 → 0x1fc00000).
- Buffer: `buf_valid`, `buf_addr` (virtual pc), `buf_data`. Hit = `ce_i` && `buf_valid` && `buf_addr`==`pc_i`.
- Bypass = state WAIT && `mem_ack_i` && `req_pc`==`pc_i` && `ce_i`.
- Output priority (combinational):
  - `rst`=0 or `ce_i`=0: all outputs 0.
  - Misaligned (`pc_i[1:0]`≠0): `exc_adel_o`=1, `inst_valid_o`=1, `inst_o`=0, `stallreq_o`=0; no memory access.
  - Hit: `inst_o`=`buf_data`, valid=1, stallreq=0.
  - Bypass: `inst_o`=`mem_rdata_i`, valid=1, stallreq=0.
  - Otherwise: valid=0, `stallreq_o`=1.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: if `ce_i`, aligned, no hit, and `flush_i`=0, latch `req_pc`=`pc_i`, register `mem_req_o`=1 with `mem_addr_o`=phys, and go to WAIT.
  - WAIT: hold `mem_req_o`/`mem_addr_o` stable. On `mem_ack_i`: drop req, write buffer {`req_pc`, `mem_rdata_i`}, go to IDLE. If `flush_i`=1 without ack, go to DRAIN. If `flush_i` and ack occur together, drop req, do not write the buffer, go to IDLE.
  - DRAIN: keep req high (a request is never withdrawn). On ack, discard data and go to IDLE.
- Buffer consume: a hit or bypass with `stall_i`=0 leaves `buf_valid`=0 after the edge. Bypass with `stall_i`=1 sets `buf_valid`=1.
- `flush_i`=1 clears `buf_valid` on every state.
- Only one transaction is ever outstanding.

## Timing
- Reset (`rst`=0 at an edge): state IDLE; `mem_req_o`=0; `mem_addr_o`=0; `buf_valid`=0; `buf_addr`=0; `buf_data`=0; `req_pc`=0. Combinational outputs are 0 while `rst`=0. Reset during WAIT/DRAIN drops the request; memory shares `rst`.
- Miss at cycle N: `stallreq_o`=1 in N, `mem_req_o`=1 from N+1. Zero-wait memory acks in N+1, so the instruction is valid (bypass) in N+1, giving 2 cycles per fetch.
- k wait cycles: valid in N+1+k; `stallreq_o` high for N..N+k.
- Stall held by CTRL: the buffered instruction is re-presented every cycle with no new request.
- Flush in N: new pc is fetched no earlier than one cycle after the DRAIN ack; stale data is never presented.

## Test plan
- Reset, then `ce_i`=1, pc=0xbfc00000, zero-wait memory with ack in the req cycle → `mem_addr_o`=0x1fc00000 in N+1, `inst_valid_o`=1 with `mem_rdata_i` in N+1, `stallreq_o`=1 only in N.
- Memory with 3 wait cycles, pc=0x80000010 → `mem_addr_o`=0x00000010 stable for 4 cycles, `stallreq_o` high N..N+3, valid in N+4.
- After data arrives, `stall_i`=1 for 5 cycles with pc held → same `inst_o` every cycle, `valid`=1, no new `mem_req_o`. `stall_i` release → next pc misses.
- `flush_i` in WAIT with pc switched to 0x80000180, ack 2 cycles later → first data discarded (valid=0), second request to 0x00000180, returned instruction correct.
- pc=0xbfc00002 → `exc_adel_o`=1, `inst_o`=0, `stallreq_o`=0, `mem_req_o` stays 0.
- `rst`=0 asserted during WAIT → next cycle `mem_req_o`=0, buffer invalid, all outputs 0.

Source files
------------

// File: rtl/inst_fetch_port.sv
// Instruction-fetch responder: kseg0/kseg1 translation, single-outstanding req/ack fetch, one-entry hold buffer.
// Latency: miss in N returns at N+1+k for k memory waits; stalls hold the buffered word and raise stallreq_o while a fetch is pending.
module inst_fetch_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        exc_adel_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic [31:0] req_pc;
    logic [31:0] phys;
    logic        aligned;
    logic        hit;
    logic        bypass;
    logic        issue;
    logic        fill;
    logic        retire;

    assign phys    = (pc_i[31:30] == 2'b10) ? {3'b000, pc_i[28:0]} : pc_i;
    assign aligned = (pc_i[1:0] == 2'b00);
    assign hit     = ce_i && buf_valid && (buf_addr == pc_i);
    assign bypass  = (state == WAIT) && mem_ack_i && (req_pc == pc_i) && ce_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        fill         = 1'b0;
        retire       = 1'b0;
        inst_o       = 32'h0;
        inst_valid_o = 1'b0;
        exc_adel_o   = 1'b0;
        stallreq_o   = 1'b0;

        case (state)
            IDLE: begin
                if (ce_i && aligned && !hit && !flush_i) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // a flush that coincides with the ack simply drops the data
                if (mem_ack_i) begin
                    retire    = 1'b1;
                    fill      = !flush_i;
                    state_nxt = IDLE;
                end else if (flush_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rst && ce_i) begin
            if (!aligned) begin
                exc_adel_o   = 1'b1;
                inst_valid_o = 1'b1;
            end else if (hit) begin
                inst_o       = buf_data;
                inst_valid_o = 1'b1;
            end else if (bypass) begin
                inst_o       = mem_rdata_i;
                inst_valid_o = 1'b1;
            end else begin
                stallreq_o   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'h0;
            req_pc     <= 32'h0;
            buf_valid  <= 1'b0;
            buf_addr   <= 32'h0;
            buf_data   <= 32'h0;
        end else begin
            // the request stays up until acked, even across a flush
            if (issue) begin
                req_pc     <= pc_i;
                mem_req_o  <= 1'b1;
                mem_addr_o <= phys;
            end else if (retire) begin
                mem_req_o  <= 1'b0;
            end

            if (flush_i) begin
                buf_valid <= 1'b0;
            end else if (fill) begin
                buf_valid <= bypass ? stall_i : 1'b1;
                buf_addr  <= req_pc;
                buf_data  <= mem_rdata_i;
            end else if ((hit || bypass) && !stall_i) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Cycle-by-cycle vector bench for inst_fetch_port with a programmable-wait memory responder.
module tb_inst_fetch_port;

    typedef struct {
        string       name;
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        int          mwait;
        logic [31:0] e_inst;
        logic        e_vld;
        logic        e_adel;
        logic        e_sreq;
        logic        e_mreq;
        logic [31:0] e_maddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] inst;
    logic        vld;
    logic        adel;
    logic        sreq;
    logic        mreq;
    logic [31:0] maddr;
    logic        mack;
    logic [31:0] mrdata;

    int mem_wait = 0;
    int mem_cnt  = 0;
    int n_vec    = 0;
    int n_miss   = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_port dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce),
        .pc_i         (pc),
        .stall_i      (stall),
        .flush_i      (flush),
        .inst_o       (inst),
        .inst_valid_o (vld),
        .exc_adel_o   (adel),
        .stallreq_o   (sreq),
        .mem_req_o    (mreq),
        .mem_addr_o   (maddr),
        .mem_ack_i    (mack),
        .mem_rdata_i  (mrdata)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A3C3C;
    endfunction

    // memory acks after mem_wait cycles of a held request; data only meaningful in the ack cycle
    always @(posedge clk) begin
        if (!rst || !mreq || mack) mem_cnt <= 0;
        else                       mem_cnt <= mem_cnt + 1;
    end

    always_comb begin
        mack   = mreq && (mem_cnt == mem_wait);
        mrdata = mack ? dat(maddr) : 32'hDEADBEEF;
    end

    function automatic vec_t mk(input string n, input logic r, input logic c, input logic [31:0] p,
                                input logic s, input logic f, input int w,
                                input logic [31:0] ei, input logic ev, input logic ea,
                                input logic es, input logic em, input logic [31:0] ema);
        vec_t v;
        v.name = n; v.rst = r; v.ce = c; v.pc = p; v.stall = s; v.flush = f; v.mwait = w;
        v.e_inst = ei; v.e_vld = ev; v.e_adel = ea; v.e_sreq = es; v.e_mreq = em; v.e_maddr = ema;
        return v;
    endfunction

    task automatic chk(input string vn, input string fld, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s.%s: got %h want %h", vn, fld, act, want);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        rst      = v.rst;
        ce       = v.ce;
        pc       = v.pc;
        stall    = v.stall;
        flush    = v.flush;
        mem_wait = v.mwait;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        chk(e.name, "inst",  inst,        e.e_inst);
        chk(e.name, "valid", {31'h0, vld},  {31'h0, e.e_vld});
        chk(e.name, "adel",  {31'h0, adel}, {31'h0, e.e_adel});
        chk(e.name, "sreq",  {31'h0, sreq}, {31'h0, e.e_sreq});
        chk(e.name, "mreq",  {31'h0, mreq}, {31'h0, e.e_mreq});
        if (e.e_mreq || !e.rst) chk(e.name, "maddr", maddr, e.e_maddr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; pc = 32'h0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //                name           rst ce pc           st fl w   inst                vld adel sreq mreq maddr
        tbl.push_back(mk("rst_idle",     0, 0, 32'h0,        0, 0, 0, 32'h0,              0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("rst_ce",       0, 1, 32'hbfc00000, 0, 0, 0, 32'h0,              0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("kseg1_miss",   1, 1, 32'hbfc00000, 0, 0, 0, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("kseg1_byp",    1, 1, 32'hbfc00000, 0, 0, 0, dat(32'h1fc00000),  1, 0, 0, 1, 32'h1fc00000));
        tbl.push_back(mk("w3_miss",      1, 1, 32'h80000010, 0, 0, 3, 32'h0,              0, 0, 1, 0, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("w3_wait",  1, 1, 32'h80000010, 0, 0, 3, 32'h0,              0, 0, 1, 1, 32'h00000010));
        tbl.push_back(mk("w3_byp",       1, 1, 32'h80000010, 1, 0, 3, dat(32'h00000010),  1, 0, 0, 1, 32'h00000010));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("stall_hold", 1, 1, 32'h80000010, 1, 0, 3, dat(32'h00000010), 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk("stall_rel",    1, 1, 32'h80000010, 0, 0, 3, dat(32'h00000010),  1, 0, 0, 0, 32'h0));
        tbl.push_back(mk("next_miss",    1, 1, 32'h80000014, 0, 0, 0, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("next_byp",     1, 1, 32'h80000014, 0, 0, 0, dat(32'h00000014),  1, 0, 0, 1, 32'h00000014));
        tbl.push_back(mk("fl_miss",      1, 1, 32'h80000020, 0, 0, 2, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("fl_wait",      1, 1, 32'h80000180, 0, 1, 2, 32'h0,              0, 0, 1, 1, 32'h00000020));
        tbl.push_back(mk("drain",        1, 1, 32'h80000180, 0, 0, 2, 32'h0,              0, 0, 1, 1, 32'h00000020));
        tbl.push_back(mk("drain_ack",    1, 1, 32'h80000180, 0, 0, 2, 32'h0,              0, 0, 1, 1, 32'h00000020));
        tbl.push_back(mk("refetch_miss", 1, 1, 32'h80000180, 0, 0, 0, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("refetch_byp",  1, 1, 32'h80000180, 0, 0, 0, dat(32'h00000180),  1, 0, 0, 1, 32'h00000180));
        tbl.push_back(mk("adel",         1, 1, 32'hbfc00002, 0, 0, 0, 32'h0,              1, 1, 0, 0, 32'h0));
        tbl.push_back(mk("adel_hold",    1, 1, 32'hbfc00003, 0, 0, 0, 32'h0,              1, 1, 0, 0, 32'h0));
        tbl.push_back(mk("ce_off",       1, 0, 32'hbfc00004, 0, 0, 0, 32'h0,              0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("kuseg_miss",   1, 1, 32'h00400000, 0, 0, 1, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("kuseg_wait",   1, 1, 32'h00400000, 0, 0, 1, 32'h0,              0, 0, 1, 1, 32'h00400000));
        tbl.push_back(mk("kuseg_byp",    1, 1, 32'h00400000, 0, 0, 1, dat(32'h00400000),  1, 0, 0, 1, 32'h00400000));
        tbl.push_back(mk("kseg2_miss",   1, 1, 32'hc0001000, 0, 0, 0, 32'h0,              0, 0, 1, 0, 32'h0));
        tbl.push_back(mk("kseg2_byp",    1, 1, 32'hc0001000, 0, 0, 0, dat(32'hc0001000),  1, 0, 0, 1, 32'hc0001000));

        foreach (tbl[i]) apply(tbl[i]);

        // reset asserted while a fetch is outstanding
        apply(mk("rw_miss",   1, 1, 32'h80000040, 0, 0, 5, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("rw_wait",   1, 1, 32'h80000040, 0, 0, 5, 32'h0,             0, 0, 1, 1, 32'h00000040));
        apply(mk("rw_rst",    0, 1, 32'h80000040, 0, 0, 5, 32'h0,             0, 0, 0, 1, 32'h00000040));
        apply(mk("rw_after",  0, 1, 32'h80000040, 0, 0, 5, 32'h0,             0, 0, 0, 0, 32'h0));
        apply(mk("rw_remiss", 1, 1, 32'h80000040, 0, 0, 0, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("rw_byp",    1, 1, 32'h80000040, 0, 0, 0, dat(32'h00000040), 1, 0, 0, 1, 32'h00000040));

        // flush coinciding with ack must not fill the buffer
        apply(mk("fa_miss",   1, 1, 32'h80000050, 0, 0, 1, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("fa_wait",   1, 1, 32'h80000050, 0, 0, 1, 32'h0,             0, 0, 1, 1, 32'h00000050));
        apply(mk("fa_ackfl",  1, 1, 32'h80000060, 0, 1, 1, 32'h0,             0, 0, 1, 1, 32'h00000050));
        apply(mk("fa_nohit",  1, 1, 32'h80000050, 0, 0, 0, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("fa_byp",    1, 1, 32'h80000050, 0, 0, 0, dat(32'h00000050), 1, 0, 0, 1, 32'h00000050));

        // flush in IDLE invalidates a held entry
        apply(mk("fb_miss",   1, 1, 32'h80000070, 0, 0, 0, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("fb_byp",    1, 1, 32'h80000070, 1, 0, 0, dat(32'h00000070), 1, 0, 0, 1, 32'h00000070));
        apply(mk("fb_hitfl",  1, 1, 32'h80000070, 1, 1, 0, dat(32'h00000070), 1, 0, 0, 0, 32'h0));
        apply(mk("fb_miss2",  1, 1, 32'h80000070, 0, 0, 0, 32'h0,             0, 0, 1, 0, 32'h0));
        apply(mk("fb_byp2",   1, 1, 32'h80000070, 0, 0, 0, dat(32'h00000070), 1, 0, 0, 1, 32'h00000070));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
